bin_to_bcd: RTL and testbench

//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).

---
 rtl/bin_to_bcd.sv | 107 ++++++++++
 tb/tb_bin_to_bcd.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, double dabble) feeding
// the seven-segment display driver; valid/ready input, one-cycle done output.
module bin_to_bcd #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  done,
    output logic                  ovf
);

    localparam int SW    = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(IN_W + 1);

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    localparam logic [31:0]      MAX_VAL = pow10(DIGITS) - 32'd1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(IN_W - 1);

    // Adjusted nibbles top out at 12, so no carry ever crosses a nibble boundary.
    function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] saturate(input logic pend,
                                                     input logic [4*DIGITS-1:0] s);
        return pend ? {DIGITS{4'h9}} : s;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t            state, state_nxt;
    logic [IN_W-1:0]   shift_reg;
    logic [SW-1:0]     scratch;
    logic [CNT_W-1:0]  count;
    logic              ovf_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (count == LAST) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    // Datapath: accept in IDLE, add-3 then shift in SHIFT, publish in LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            ovf_pend  <= 1'b0;
            bcd_out   <= '0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        count     <= '0;
                        ovf_pend  <= (32'(bin_in) > MAX_VAL);
                    end
                end
                SHIFT: begin
                    {scratch, shift_reg} <= {add3(scratch), shift_reg} << 1;
                    count                <= count + CNT_W'(1);
                end
                LOAD: begin
                    bcd_out <= saturate(ovf_pend, scratch[4*DIGITS-1:0]);
                    ovf     <= ovf_pend;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd: latency, conversion values,
// saturation, busy-ignore, back-to-back accept and mid-conversion reset.
module tb_bin_to_bcd;

    logic        clk;
    logic        reset;
    logic [13:0] bin_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_out;
    logic        done;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    bin_to_bcd #(.IN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bin_in   (bin_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd_out  (bcd_out),
        .done     (done),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a value for one cycle; the following posedge is the accept edge.
    task automatic accept(input logic [13:0] v);
        @(negedge clk);
        bin_in   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges counted after the current point until done is seen; 0 on timeout.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bcd_out !== 16'h0000) begin bad++; $display("FAIL reset_bcd: got %h expected 0000", bcd_out); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_convert;
        logic [13:0] vals [3];
        logic [15:0] exps [3];
        int cyc;
        vals = '{14'd1234, 14'd9999, 14'd0};
        exps = '{16'h1234, 16'h9999, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            accept(vals[i]);
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL conv_busy_%0d: ready got %b expected 0", i, in_ready); end
            wait_done(cyc);
            total++;
            if (cyc !== 15) begin bad++; $display("FAIL conv_latency_%0d: got %0d expected 15", i, cyc); end
            total++;
            if (bcd_out !== exps[i]) begin bad++; $display("FAIL conv_bcd_%0d: got %h expected %h", i, bcd_out, exps[i]); end
            total++;
            if (ovf !== 1'b0) begin bad++; $display("FAIL conv_ovf_%0d: got %b expected 0", i, ovf); end
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL conv_ready_done_%0d: got %b expected 1", i, in_ready); end
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0) begin bad++; $display("FAIL conv_done_pulse_%0d: got %b expected 0", i, done); end
            repeat (3) @(posedge clk);
            #1;
            total++;
            if (bcd_out !== exps[i]) begin bad++; $display("FAIL conv_hold_%0d: got %h expected %h", i, bcd_out, exps[i]); end
        end
    endtask

    task automatic test_overflow;
        logic [13:0] vals [2];
        int cyc;
        vals = '{14'd10000, 14'd16383};
        for (int i = 0; i < 2; i++) begin
            accept(vals[i]);
            wait_done(cyc);
            total++;
            if (cyc !== 15) begin bad++; $display("FAIL ovf_latency_%0d: got %0d expected 15", i, cyc); end
            total++;
            if (bcd_out !== 16'h9999) begin bad++; $display("FAIL ovf_bcd_%0d: got %h expected 9999", i, bcd_out); end
            total++;
            if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag_%0d: got %b expected 1", i, ovf); end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        accept(14'd42);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bin_in   = 14'd777;
            in_valid = 1'b1;
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy_%0d: ready got %b expected 0", k, in_ready); end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_done(cyc);
        total++;
        if (cyc + 3 !== 15) begin bad++; $display("FAIL b2b_latency_42: got %0d expected 15", cyc + 3); end
        total++;
        if (bcd_out !== 16'h0042) begin bad++; $display("FAIL b2b_bcd_42: got %h expected 0042", bcd_out); end
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf_42: got %b expected 0", ovf); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_done: got %b expected 1", in_ready); end
        bin_in   = 14'd777;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accepted: ready got %b expected 0", in_ready); end
        wait_done(cyc);
        total++;
        if (cyc !== 15) begin bad++; $display("FAIL b2b_latency_777: got %0d expected 15", cyc); end
        total++;
        if (bcd_out !== 16'h0777) begin bad++; $display("FAIL b2b_bcd_777: got %h expected 0777", bcd_out); end
    endtask

    task automatic test_abort;
        int cyc;
        int seen;
        accept(14'd5555);
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (bcd_out !== 16'h0000) begin bad++; $display("FAIL abort_bcd: got %h expected 0000", bcd_out); end
        total++;
        if (ovf !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_flags: got ovf=%b done=%b expected 0 0", ovf, done); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b expected 1", in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
        accept(14'd321);
        wait_done(cyc);
        total++;
        if (cyc !== 15) begin bad++; $display("FAIL abort_latency_321: got %0d expected 15", cyc); end
        total++;
        if (bcd_out !== 16'h0321) begin bad++; $display("FAIL abort_bcd_321: got %h expected 0321", bcd_out); end
    endtask

    initial begin
        test_reset;
        test_convert;
        test_overflow;
        test_back_to_back;
        test_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
